// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the RV32 subset core (R-type, ADDI, LW, SW, BEQ).
// Outputs are decoded from the current state and inputs; only state, wait and retire counters are stored.
module multicycle_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [31:0]      instr_i,
    input  logic             zero_i,
    input  logic             imem_ack_i,
    input  logic             dmem_ack_i,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic [1:0]       imm_sel_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_we_o,
    output logic             wb_sel_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int unsigned      WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_WB, S_BRANCH, S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic [6:0]         opcode;
    logic               is_addi, is_lw, is_sw;

    assign opcode  = instr_i[6:0];
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_src_o   = 1'b0;
        imm_sel_o  = 2'd0;
        alu_src_o  = 1'b0;
        alu_op_o   = 2'b00;
        reg_we_o   = 1'b0;
        wb_sel_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_ADDI: state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    default:       state_d = S_ERR;
                endcase
            end
            S_EXEC: begin
                alu_op_o  = 2'b10;
                alu_src_o = is_addi;
                state_d   = S_WB;
            end
            S_ADDR: begin
                alu_op_o  = 2'b00;
                alu_src_o = 1'b1;
                imm_sel_o = is_sw ? 2'd1 : 2'd0;
                state_d   = S_MEM;
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_sw;
                if (dmem_ack_i) begin
                    if (is_sw) retire = 1'b1;
                    else       state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                reg_we_o = 1'b1;
                wb_sel_o = is_lw;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                alu_op_o  = 2'b01;
                imm_sel_o = 2'd2;
                pc_src_o  = zero_i;
                retire    = 1'b1;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // stop_i only matters at the retire boundary
        if (retire) begin
            pc_we_o = 1'b1;
            state_d = stop_i ? S_IDLE : S_FETCH;
        end
    end

    // Wait counter runs only while a memory request stays pending in the same state
    always_comb begin
        wait_d = '0;
        if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q))
            wait_d = wait_q + WAIT_W'(1);
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    assign retired_o = retired_q;
    assign busy_o    = (state_q != S_IDLE) && (state_q != S_ERR);
    assign err_o     = (state_q == S_ERR);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output schedule from the instruction class and the chosen ack delays.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO    = 16;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // Output vector bit masks (see outv packing below)
    localparam logic [14:0] O_IREQ  = 15'h4000;
    localparam logic [14:0] O_DREQ  = 15'h2000;
    localparam logic [14:0] O_DWE   = 15'h1000;
    localparam logic [14:0] O_IRWE  = 15'h0800;
    localparam logic [14:0] O_PCWE  = 15'h0400;
    localparam logic [14:0] O_PCSRC = 15'h0200;
    localparam logic [14:0] O_IMM_B = 15'h0100;
    localparam logic [14:0] O_IMM_S = 15'h0080;
    localparam logic [14:0] O_ASRC  = 15'h0040;
    localparam logic [14:0] O_OP_FN = 15'h0020;
    localparam logic [14:0] O_OP_SB = 15'h0010;
    localparam logic [14:0] O_REGWE = 15'h0008;
    localparam logic [14:0] O_WBSEL = 15'h0004;
    localparam logic [14:0] O_BUSY  = 15'h0002;
    localparam logic [14:0] O_ERR   = 15'h0001;
    localparam logic [14:0] O_NONE  = 15'h0000;

    logic             clk, rst_i, start_i, stop_i, zero_i, imem_ack_i, dmem_ack_i;
    logic [31:0]      instr_i;
    logic             imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_src_o;
    logic [1:0]       imm_sel_o, alu_op_o;
    logic             alu_src_o, reg_we_o, wb_sel_o, busy_o, err_o;
    logic [CNT_W-1:0] retired_o;
    logic [14:0]      outv;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  retired_m = 0;
    bit  idle_flag = 1'b1;

    multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .instr_i(instr_i), .zero_i(zero_i), .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
        .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .imm_sel_o(imm_sel_o),
        .alu_src_o(alu_src_o), .alu_op_o(alu_op_o), .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o),
        .busy_o(busy_o), .err_o(err_o), .retired_o(retired_o)
    );

    assign outv = {imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_src_o, imm_sel_o,
                   alu_src_o, alu_op_o, reg_we_o, wb_sel_o, busy_o, err_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare outputs mid-cycle, then advance to just after the next rising edge
    task automatic step(input string tag, input logic [14:0] exp);
        @(negedge clk);
        check_eq(tag, 32'(outv), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_misc();
        start_i = 1'($urandom);
        stop_i  = 1'($urandom);
        zero_i  = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        retired_m = 0;
        idle_flag = 1'b1;
        @(negedge clk);
        check_eq("rst_outputs", 32'(outv), 32'(O_NONE));
        check_eq("rst_retired", 32'(retired_o), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic leave_idle();
        if (idle_flag) begin
            stop_i = 1'($urandom); zero_i = 1'($urandom);
            start_i = 1'b0;
            step("idle_hold", O_NONE);
            start_i = 1'b1;
            step("idle_start", O_NONE);
            idle_flag = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] instr, input int fdly);
        instr_i = instr;
        for (int k = 0; k <= fdly; k++) begin
            rnd_misc();
            imem_ack_i = (k == fdly);
            step("fetch", O_BUSY | O_IREQ | ((k == fdly) ? O_IRWE : O_NONE));
        end
        imem_ack_i = 1'b0;
        rnd_misc();
        step("decode", O_BUSY);
    endtask

    // zsel: 0/1 forces zero_i in the branch cycle, 2 leaves it random
    task automatic run_instr(input logic [31:0] instr, input int fdly, input int mdly, input int zsel);
        logic [6:0]  op;
        logic [14:0] e;
        bit          stop_now;
        op = instr[6:0];
        stop_now = 1'b0;
        leave_idle();
        fetch(instr, fdly);
        case (op)
            OP_R, OP_ADDI: begin
                rnd_misc();
                step("exec", O_BUSY | O_OP_FN | ((op == OP_ADDI) ? O_ASRC : O_NONE));
                rnd_misc(); stop_now = stop_i;
                step("wb_alu", O_BUSY | O_REGWE | O_PCWE);
            end
            OP_LW, OP_SW: begin
                rnd_misc();
                step("addr", O_BUSY | O_ASRC | ((op == OP_SW) ? O_IMM_S : O_NONE));
                for (int k = 0; k <= mdly; k++) begin
                    rnd_misc();
                    dmem_ack_i = (k == mdly);
                    e = O_BUSY | O_DREQ;
                    if (op == OP_SW) e = e | O_DWE;
                    if (op == OP_SW && k == mdly) begin
                        e = e | O_PCWE;
                        stop_now = stop_i;
                    end
                    step("mem", e);
                end
                dmem_ack_i = 1'b0;
                if (op == OP_LW) begin
                    rnd_misc(); stop_now = stop_i;
                    step("wb_load", O_BUSY | O_REGWE | O_WBSEL | O_PCWE);
                end
            end
            default: begin
                rnd_misc();
                if (zsel < 2) zero_i = zsel[0];
                stop_now = stop_i;
                step("branch", O_BUSY | O_OP_SB | O_IMM_B | O_PCWE | (zero_i ? O_PCSRC : O_NONE));
            end
        endcase
        retired_m = (retired_m + 1) % (1 << CNT_W);
        check_eq("retired", 32'(retired_o), 32'(retired_m));
        idle_flag = stop_now;
    endtask

    task automatic err_hold(input int n);
        for (int k = 0; k < n; k++) begin
            rnd_misc();
            imem_ack_i = 1'($urandom);
            dmem_ack_i = 1'($urandom);
            step("err_state", O_ERR);
        end
        imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        check_eq("err_retired", 32'(retired_o), 32'(retired_m));
    endtask

    initial begin
        logic [6:0]  ops [5];
        logic [31:0] r;
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; zero_i = 1'b0;
        imem_ack_i = 1'b0; dmem_ack_i = 1'b0; instr_i = 32'h0;
        do_reset();

        // Directed: ADDI, LW with 3-cycle ack wait, SW, BEQ taken and not taken
        run_instr(32'h00500093, 0, 0, 2);
        run_instr(32'h0000a103, 0, 3, 2);
        run_instr(32'h0020a023, 1, 1, 2);
        run_instr(32'h00208063, 0, 0, 1);
        run_instr(32'h00208063, 2, 0, 0);
        // Acks arriving on the last allowed wait cycle still win
        run_instr(32'h00500093, int'(TO) - 1, 0, 2);
        run_instr(32'h0000a103, 0, int'(TO) - 1, 2);
        run_instr(32'h0020a023, 0, int'(TO) - 1, 2);

        // Random mix, long enough to wrap the retire counter
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            run_instr({r[31:7], ops[$urandom_range(0, 4)]}, $urandom_range(0, 4), $urandom_range(0, 4), 2);
        end

        // Reset while a load is waiting on dmem
        leave_idle();
        fetch(32'h0000a103, 0);
        rnd_misc();
        step("addr_pre_rst", O_BUSY | O_ASRC);
        dmem_ack_i = 1'b0;
        step("mem_pre_rst", O_BUSY | O_DREQ);
        step("mem_pre_rst", O_BUSY | O_DREQ);
        do_reset();

        // Illegal opcode
        leave_idle();
        fetch(32'h0000007f, 0);
        err_hold(6);
        do_reset();

        // imem never acks
        leave_idle();
        instr_i = 32'h00500093;
        for (int k = 0; k < int'(TO); k++) begin
            rnd_misc();
            step("fetch_wait", O_BUSY | O_IREQ);
        end
        err_hold(4);
        do_reset();

        // dmem never acks on a store
        run_instr(32'h00500093, 0, 0, 2);
        leave_idle();
        fetch(32'h0020a023, 0);
        rnd_misc();
        step("addr_to", O_BUSY | O_ASRC | O_IMM_S);
        for (int k = 0; k < int'(TO); k++) begin
            rnd_misc();
            step("mem_wait", O_BUSY | O_DREQ | O_DWE);
        end
        err_hold(4);
        do_reset();
        run_instr(32'h00500093, 0, 0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
